// File: rtl/cla_pkg.sv
// ============================================================================
// Module      : cla_pkg
// Description : Shared width, group size and saturation constants for the
//               16-bit carry-lookahead saturating adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cla_pkg;

  localparam int WIDTH   = 16;
  localparam int GROUP   = 4;
  localparam int NGROUPS = WIDTH / GROUP;

  typedef logic [WIDTH-1:0] word_t;

  localparam word_t SAT_POS = 16'h7FFF;
  localparam word_t SAT_NEG = 16'h8000;

  // Overflow clamps take priority over the raw sum; the two flags are exclusive.
  function automatic word_t saturate(input word_t raw, input logic pos_ovf,
                                     input logic neg_ovf);
    word_t res;
    res = raw;
    if (pos_ovf) res = SAT_POS;
    else if (neg_ovf) res = SAT_NEG;
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla_4bit.sv
// ============================================================================
// Module      : cla_4bit
// Description : 4-bit carry-lookahead group producing the sum bits plus the
//               group propagate/generate used by the second lookahead level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_4bit
  import cla_pkg::*;
(
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             Pg,
  output logic             Gg
);

  logic [GROUP-1:0] w_p;
  logic [GROUP-1:0] w_g;
  logic [GROUP-1:0] w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Every internal carry is a flat sum of products of cin, no ripple.
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);

  assign s  = w_p ^ w_c;
  assign Pg = &w_p;
  assign Gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
            | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule

`default_nettype wire

// File: rtl/cla_16bit.sv
// ============================================================================
// Module      : cla_16bit
// Description : 16-bit two-level carry-lookahead adder/subtractor with signed
//               saturation and a registered S/Cout/Error output stage.
//               Saturation is enabled by defining CLA_SAT_EN; otherwise S wraps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_16bit
  import cla_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Error
);

  word_t              w_beff;
  word_t              w_raw;
  word_t              w_result;
  logic [NGROUPS-1:0] w_pg;
  logic [NGROUPS-1:0] w_gg;
  logic [NGROUPS:0]   w_gc;
  logic               w_pos_ovf;
  logic               w_neg_ovf;

  word_t              r_s;
  logic               r_cout;
  logic               r_error;

  assign w_beff  = B ^ {WIDTH{Sub}};
  assign w_gc[0] = Sub;

  for (genvar gi = 0; gi < NGROUPS; gi++) begin : g_group
    cla_4bit u_grp (
      .a   (A[gi*GROUP +: GROUP]),
      .b   (w_beff[gi*GROUP +: GROUP]),
      .cin (w_gc[gi]),
      .s   (w_raw[gi*GROUP +: GROUP]),
      .Pg  (w_pg[gi]),
      .Gg  (w_gg[gi])
    );
  end

  // Second-level lookahead: each group carry depends only on Pg/Gg and c0.
  assign w_gc[1] = w_gg[0] | (w_pg[0] & w_gc[0]);
  assign w_gc[2] = w_gg[1] | (w_pg[1] & w_gg[0]) | (w_pg[1] & w_pg[0] & w_gc[0]);
  assign w_gc[3] = w_gg[2] | (w_pg[2] & w_gg[1]) | (w_pg[2] & w_pg[1] & w_gg[0])
                 | (w_pg[2] & w_pg[1] & w_pg[0] & w_gc[0]);
  assign w_gc[4] = w_gg[3] | (w_pg[3] & w_gg[2]) | (w_pg[3] & w_pg[2] & w_gg[1])
                 | (w_pg[3] & w_pg[2] & w_pg[1] & w_gg[0])
                 | (w_pg[3] & w_pg[2] & w_pg[1] & w_pg[0] & w_gc[0]);

  assign w_pos_ovf = ~A[WIDTH-1] & ~w_beff[WIDTH-1] &  w_raw[WIDTH-1];
  assign w_neg_ovf =  A[WIDTH-1] &  w_beff[WIDTH-1] & ~w_raw[WIDTH-1];

`ifdef CLA_SAT_EN
  assign w_result = saturate(w_raw, w_pos_ovf, w_neg_ovf);
`else
  assign w_result = w_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_s     <= w_result;
      r_cout  <= w_gc[NGROUPS];
      r_error <= w_pos_ovf | w_neg_ovf;
    end
  end

  assign S     = r_s;
  assign Cout  = r_cout;
  assign Error = r_error;

endmodule

`default_nettype wire

// File: tb/tb_cla_16bit.sv
// ============================================================================
// Module      : tb_cla_16bit
// Description : Self-checking bench for cla_16bit against an integer model;
//               expectations follow CLA_SAT_EN the same way the design does.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cla_16bit;

  logic        clk;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic        Sub;
  logic [15:0] S;
  logic        Cout;
  logic        Error;

  int n_tests = 0;
  int n_fail  = 0;

  cla_16bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .Sub   (Sub),
    .S     (S),
    .Cout  (Cout),
    .Error (Error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: exact signed arithmetic in int, then clamp or wrap.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic sub);
    int          sa;
    int          sb;
    int          t;
    logic        err;
    logic [16:0] u;
    logic [15:0] s;
    sa  = $signed(a);
    sb  = $signed(b);
    t   = sub ? sa - sb : sa + sb;
    err = (t > 32767) || (t < -32768);
    u   = sub ? ({1'b0, a} + 17'h10000 - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
`ifdef CLA_SAT_EN
    if (t > 32767)       s = 16'h7FFF;
    else if (t < -32768) s = 16'h8000;
    else                 s = t[15:0];
`else
    s = t[15:0];
`endif
    return {s, u[16], err};
  endfunction

  // Drive one operation, wait one edge, compare all three outputs with the model.
  task automatic apply(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic sub);
    logic [17:0] exp;
    A   = a;
    B   = b;
    Sub = sub;
    exp = model(a, b, sub);
    @(posedge clk);
    #1;
    check({tag, "_s"},   32'(S),     32'(exp[17:2]));
    check({tag, "_c"},   32'(Cout),  32'(exp[1]));
    check({tag, "_err"}, 32'(Error), 32'(exp[0]));
  endtask

  function automatic logic [15:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    A     = 16'($urandom);
    B     = 16'($urandom);
    Sub   = 1'($urandom);

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      A = 16'($urandom);
      B = 16'($urandom);
      check("rst_s", 32'(S), 32'h0);
      check("rst_c", 32'(Cout), 32'h0);
      check("rst_err", 32'(Error), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    apply("add15_4", 16'd15, 16'd4, 1'b0);
    check("add15_4_val", 32'(S), 32'd19);
    check("add15_4_e", 32'(Error), 32'd0);

    apply("possat", 16'd32767, 16'd32767, 1'b0);
    check("possat_e", 32'(Error), 32'd1);
    check("possat_c", 32'(Cout), 32'd0);
`ifdef CLA_SAT_EN
    check("possat_val", 32'(S), 32'h7FFF);
`else
    check("possat_val", 32'(S), 32'hFFFE);
`endif

    apply("negsat", 16'h8001, 16'h8001, 1'b0);
    check("negsat_e", 32'(Error), 32'd1);
    check("negsat_c", 32'(Cout), 32'd1);

    apply("mixed", 16'd15, 16'hFFF8, 1'b0);
    check("mixed_val", 32'(S), 32'd7);
    check("mixed_c", 32'(Cout), 32'd1);

    apply("sub15_8", 16'd15, 16'd8, 1'b1);
    check("sub15_8_val", 32'(S), 32'd7);

    apply("sub8_m8", 16'd8, 16'hFFF8, 1'b1);
    check("sub8_m8_val", 32'(S), 32'd16);
    check("sub8_m8_e", 32'(Error), 32'd0);

    apply("sub0_min", 16'h0000, 16'h8000, 1'b1);
    check("sub0_min_e", 32'(Error), 32'd1);
`ifdef CLA_SAT_EN
    check("sub0_min_val", 32'(S), 32'h7FFF);
`else
    check("sub0_min_val", 32'(S), 32'h8000);
`endif

    apply("subneg_min", 16'hFFFF, 16'h8000, 1'b1);
    check("subneg_min_val", 32'(S), 32'h7FFF);

    // Back-to-back random traffic, one operation per cycle.
    for (int i = 0; i < 300; i++)
      apply("rnd", rand_word(), rand_word(), 1'($urandom));

    // Asynchronous reset in mid-flight: outputs clear without a clock edge.
    A   = 16'h7FFF;
    B   = 16'h0001;
    Sub = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_s", 32'(S), 32'h0);
    check("arst_c", 32'(Cout), 32'h0);
    check("arst_err", 32'(Error), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("arst_hold", 32'(S), 32'h0);

    for (int i = 0; i < 50; i++)
      apply("rnd2", rand_word(), rand_word(), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cla_16bit.md
# cla_16bit

16-bit two's-complement saturating adder/subtractor built on a two-level carry-lookahead tree, with a registered output stage. It serves as the datapath ALU's add/sub unit. It computes A+B or A−B and clamps signed overflow to the most positive or most negative value. It also reports the raw carry-out and an overflow/error flag.

## Interface
- Parameters: none. Width is fixed at 16 and taken from the package constant.
- clk  input  1  single clock; all outputs register on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- A  input  16  operand A, two's complement.
- B  input  16  operand B, two's complement.
- Sub  input  1  0 = A+B; 1 = A−B.
- S  output  16  registered (saturated) result.
- Cout  output  1  registered unsigned carry-out of bit 15 from the raw (pre-saturation) sum.
- Error  output  1  registered signed-overflow flag; 1 when saturation was applied (or would have been, see Configuration).

## Operation
- Operand B path: Beff = Sub ? ~B : B; carry-in c0 = Sub.
- Raw sum R = A + Beff + c0, formed with four 4-bit CLA groups.
  - Each group produces bit propagate/generate signals and a group propagate Pg/generate Gg.
  - A second-level lookahead unit computes group carries c4, c8, c12 and c16 from Pg/Gg and c0.
  - No ripple between groups.
- Overflow detection:
  - pos_ovf = ~A[15] & ~Beff[15] & R[15].
  - neg_ovf = A[15] & Beff[15] & ~R[15].
- Saturation:
  - pos_ovf → 16'h7FFF.
  - neg_ovf → 16'h8000.
  - Otherwise the result is R.
- Error = pos_ovf | neg_ovf.
- Cout = c16, the raw carry, unaffected by saturation.
- Boundaries:
  - A−B with B = 16'h8000: Beff = 16'h7FFF, c0 = 1; the overflow rules above apply unchanged (e.g. 0 − (−32768) saturates to 16'h7FFF, Error = 1).
  - Zero results: no special flag.
  - Unsigned carry never causes saturation.

## Timing
- Combinational CLA and saturation logic feeds one output register bank (S, Cout, Error).
- Latency is 1 cycle: inputs present before rising edge k appear on the outputs after edge k.
- Throughput is 1 operation per cycle; no handshake, no stall.
- Reset: rst_n low immediately forces S = 16'h0000, Cout = 0, Error = 0, independent of clk. Values are held until the first rising edge after rst_n deasserts.
- Reset asserted mid-operation discards the in-flight result. No state other than the output registers exists.

## Configuration
- CLA_SAT_EN defined: saturation as described in Operation.
- CLA_SAT_EN undefined:
  - S = R (two's-complement wrap-around).
  - Error and Cout are still computed and reported identically.
- Latency and reset behaviour are identical in both builds.

## Structure
- Package cla_pkg holds:
  - WIDTH = 16, GROUP = 4;
  - SAT_POS = 16'h7FFF, SAT_NEG = 16'h8000;
  - a typedef word_t = logic [WIDTH-1:0].
- Sub-module cla_4bit: inputs a[3:0], b[3:0], cin; outputs s[3:0], Pg, Gg.
  - Instantiated four times.
  - The second-level lookahead and the saturation/register logic live in the top module.

## Test plan
- Reset: hold rst_n = 0 with random A/B → S = 0, Cout = 0, Error = 0. Release rst_n and apply A = 15, B = 4, Sub = 0 → after one edge S = 19, Error = 0.
- Positive saturation: A = 32767, B = 32767, Sub = 0 → S = 16'h7FFF, Error = 1, Cout = 0. Without CLA_SAT_EN, S = 16'hFFFE.
- Negative saturation: A = −32767 (16'h8001), B = −32767, Sub = 0 → S = 16'h8000, Error = 1, Cout = 1.
- Mixed-sign add: A = 15, B = −8 → S = 7, Error = 0, Cout = 1.
- Subtraction: A = 15, B = 8, Sub = 1 → S = 7. A = 8, B = −8, Sub = 1 → S = 16, Error = 0.
- Edge and latency check:
  - A = 0, B = 16'h8000, Sub = 1 → S = 16'h7FFF, Error = 1.
  - Back-to-back operands on consecutive cycles each appear exactly one cycle later.
